// File: rtl/accel_msg_ingress_buffer.sv
// Store-and-forward flit buffer in front of the Tinsel accelerator: a message is
// released only once its final flit is buffered, with cut-through for oversize messages.
module accel_msg_ingress_buffer #(
    parameter int FLIT_W = 0,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FLIT_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [FLIT_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   msg_count,
    output logic                     oversize_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        STORE,
        CUT
    } state_t;

    // An idle token always terminates its message, whatever notFinalFlit says.
    function automatic logic is_final(input logic [FLIT_W-1:0] flit);
        return !flit[1] || flit[0];
    endfunction

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    state_t            state;
    state_t            state_nxt;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              in_final;
    logic              head_final;

    assign full       = (level == CW'(DEPTH));
    assign empty      = (level == '0);
    assign in_ready   = !full;
    assign out_data   = mem[rd_ptr];
    assign in_final   = is_final(in_data);
    assign head_final = is_final(out_data);
    assign out_valid  = (state == CUT) ? !empty : (msg_count != '0);
    assign push       = in_valid && !full;
    assign pop        = out_valid && out_ready;

    // A full buffer with no complete message means the head message can never
    // fit, so it is streamed through until its final flit leaves.
    always_comb begin
        state_nxt = state;
        case (state)
            STORE:   if (full && (msg_count == '0)) state_nxt = CUT;
            CUT:     if (pop && head_final)         state_nxt = STORE;
            default: state_nxt = STORE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state        <= STORE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            msg_count    <= '0;
            oversize_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            level     <= level + CW'(push) - CW'(pop);
            msg_count <= msg_count + CW'(push && in_final) - CW'(pop && head_final);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if ((state == STORE) && (state_nxt == CUT)) oversize_err <= 1'b1;
        end
    end

    // Storage array carries data only and is deliberately left unreset.
    always_ff @(negedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: tb/tb_accel_msg_ingress_buffer.sv
// Self-checking bench for accel_msg_ingress_buffer: FIFO scoreboard on the output
// stream plus directed checks of withholding, cut-through and reset behaviour.
module tb_accel_msg_ingress_buffer;

    localparam int FLIT_W = 18;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [FLIT_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [FLIT_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     level;
    logic [CW-1:0]     msg_count;
    logic              oversize_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [FLIT_W-1:0] sb [$];

    accel_msg_ingress_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .msg_count(msg_count), .oversize_err(oversize_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flit = {payload[15:0], notFinalFlit, isIdleToken}
    function automatic logic [FLIT_W-1:0] mk(input logic [15:0] pl, input logic nf, input logic idle);
        return {pl, nf, idle};
    endfunction

    // Posedge sits midway between state-update edges, so these are the values
    // the next falling edge will act on.
    always @(posedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else check("out_data", 32'(out_data), 32'(sb.pop_front()));
            end
            if (in_valid && in_ready) sb.push_back(in_data);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_flit(input logic [FLIT_W-1:0] f);
        bit ok = 1'b0;
        in_data  = f;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("push_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (level == '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_msg", 32'(msg_count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_oversize", 32'(oversize_err), 32'd0);

        // Single-flit message, forwarded one cycle after push
        out_ready = 1'b1;
        push_flit(mk(16'hABCD, 1'b0, 1'b0));
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data", 32'(out_data), 32'(mk(16'hABCD, 1'b0, 1'b0)));
        check("t1_msg", 32'(msg_count), 32'd1);
        tick();
        check("t1_level_end", 32'(level), 32'd0);
        check("t1_msg_end", 32'(msg_count), 32'd0);
        check("t1_ov_end", 32'(out_valid), 32'd0);

        // Three-flit message withheld until the final flit arrives
        push_flit(mk(16'h1111, 1'b1, 1'b0));
        check("t2_withhold0", 32'(out_valid), 32'd0);
        push_flit(mk(16'h2222, 1'b1, 1'b0));
        check("t2_withhold1", 32'(out_valid), 32'd0);
        check("t2_msg_pre", 32'(msg_count), 32'd0);
        push_flit(mk(16'h3333, 1'b0, 1'b0));
        check("t2_release", 32'(out_valid), 32'd1);
        check("t2_level3", 32'(level), 32'd3);
        check("t2_msg1", 32'(msg_count), 32'd1);
        tick();
        check("t2_level2", 32'(level), 32'd2);
        check("t2_msg_mid", 32'(msg_count), 32'd1);
        tick();
        check("t2_level1", 32'(level), 32'd1);
        tick();
        check("t2_level0", 32'(level), 32'd0);
        check("t2_msg0", 32'(msg_count), 32'd0);

        // Idle token with notFinalFlit set is still a complete message
        out_ready = 1'b0;
        push_flit(mk(16'h0000, 1'b1, 1'b1));
        check("t3_out_valid", 32'(out_valid), 32'd1);
        check("t3_msg", 32'(msg_count), 32'd1);
        out_ready = 1'b1;
        tick();
        check("t3_level_end", 32'(level), 32'd0);
        check("t3_msg_end", 32'(msg_count), 32'd0);

        // Fill with single-flit messages, then stream push+pop through the wrap
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_flit(mk(16'(16'h0100 + i), 1'b0, 1'b0));
        check("t4_in_ready", 32'(in_ready), 32'd0);
        check("t4_level", 32'(level), 32'd16);
        check("t4_msg", 32'(msg_count), 32'd16);
        out_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            in_data  = mk(16'(16'h0200 + k), 1'b0, 1'b0);
            in_valid = 1'b1;
            tick();
            check("t4_stream_level", 32'(level), 32'd15);
            check("t4_stream_msg", 32'(msg_count), 32'd15);
        end
        in_valid = 1'b0;
        wait_drain();
        check("t4_msg_end", 32'(msg_count), 32'd0);

        // 20-flit message overflows the buffer and cuts through
        for (int i = 0; i < 20; i++) begin
            push_flit(mk(16'(16'h0300 + i), (i != 19), 1'b0));
            if (i == 15) begin
                check("t5_full_level", 32'(level), 32'd16);
                check("t5_full_withheld", 32'(out_valid), 32'd0);
            end
        end
        check("t5_oversize", 32'(oversize_err), 32'd1);
        wait_drain();
        check("t5_msg_end", 32'(msg_count), 32'd0);
        check("t5_oversize_sticky", 32'(oversize_err), 32'd1);
        push_flit(mk(16'h0401, 1'b1, 1'b0));
        check("t5_back_to_store", 32'(out_valid), 32'd0);
        push_flit(mk(16'h0402, 1'b0, 1'b0));
        check("t5_2flit_release", 32'(out_valid), 32'd1);
        wait_drain();

        // Reset in the middle of a message discards it
        out_ready = 1'b0;
        push_flit(mk(16'h0501, 1'b1, 1'b0));
        push_flit(mk(16'h0502, 1'b1, 1'b0));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_level", 32'(level), 32'd0);
        check("t6_msg", 32'(msg_count), 32'd0);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_oversize_clr", 32'(oversize_err), 32'd0);
        out_ready = 1'b1;
        push_flit(mk(16'h0601, 1'b1, 1'b0));
        push_flit(mk(16'h0602, 1'b1, 1'b0));
        push_flit(mk(16'h0603, 1'b1, 1'b0));
        check("t6_withhold", 32'(out_valid), 32'd0);
        push_flit(mk(16'h0604, 1'b0, 1'b0));
        check("t6_release", 32'(out_valid), 32'd1);
        wait_drain();
        check("t6_msg_end", 32'(msg_count), 32'd0);

        tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
